// File: rtl/wave_serializer.sv
// I2S output stage: buffers filtered mono samples in a small FIFO and sends
// each one on both channels of a 64-BitClk stereo frame.
module wave_serializer #(
    parameter int SAMPLE_WIDTH    = 24,
    parameter int CLK_DIV         = 4,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [SAMPLE_WIDTH-1:0]    WaveIn,
    input  logic                       WaveValid,
    output logic                       WaveReady,
    input  logic                       Mute,
    output logic                       BitClk,
    output logic                       WordSel,
    output logic                       SerialData,
    output logic [FIFO_DEPTH_LOG2:0]   FifoLevel,
    output logic [7:0]                 Underrun
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0]           r_div;
    logic                       r_bclk;
    logic [5:0]                 r_cnt;
    logic                       r_wsel;
    logic                       r_sd;
    logic [SAMPLE_WIDTH-1:0]    r_sample;
    logic [7:0]                 r_underrun;
    logic [FIFO_DEPTH_LOG2:0]   r_level;
    logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [SAMPLE_WIDTH-1:0]    r_mem [DEPTH];

    logic                       w_wrap;
    logic                       w_fall;
    logic                       w_frame_start;
    logic [5:0]                 w_cnt_nxt;
    logic [4:0]                 w_pos;
    logic [5:0]                 w_idx;
    logic                       w_bit;
    logic                       w_empty;
    logic                       w_push;
    logic                       w_pop;

    assign w_wrap        = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_fall        = w_wrap && r_bclk;
    assign w_cnt_nxt     = r_cnt + 6'd1;
    assign w_frame_start = w_fall && (r_cnt == 6'd63);
    assign w_pos         = w_cnt_nxt[4:0];

    assign w_empty   = (r_level == '0);
    assign WaveReady = (r_level != (FIFO_DEPTH_LOG2+1)'(DEPTH));
    assign w_push    = WaveValid && WaveReady;
    // An empty FIFO cannot be popped even if a push lands the same cycle.
    assign w_pop     = w_frame_start && !w_empty;

    // One-bit I2S delay: slot position 0 is blank, MSB follows, then zero pad.
    always_comb begin
        w_idx = 6'(SAMPLE_WIDTH) - {1'b0, w_pos};
        w_bit = 1'b0;
        if (w_pos >= 5'd1 && {1'b0, w_pos} <= 6'(SAMPLE_WIDTH))
            w_bit = r_sample[w_idx];
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
        end else if (w_wrap) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
        end else begin
            r_div  <= r_div + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_cnt      <= 6'd63;
            r_wsel     <= 1'b0;
            r_sd       <= 1'b0;
            r_sample   <= '0;
            r_underrun <= '0;
        end else if (w_fall) begin
            r_cnt  <= w_cnt_nxt;
            r_wsel <= w_cnt_nxt[5];
            r_sd   <= w_bit;
            if (w_frame_start) begin
                r_sample <= (Mute || w_empty) ? '0 : r_mem[r_rd_ptr];
                if (w_empty && r_underrun != 8'hFF)
                    r_underrun <= r_underrun + 8'd1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_level  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge Clock) begin
        if (w_push) r_mem[r_wr_ptr] <= WaveIn;
    end

    assign BitClk     = r_bclk;
    assign WordSel    = r_wsel;
    assign SerialData = r_sd;
    assign FifoLevel  = r_level;
    assign Underrun   = r_underrun;

endmodule

// File: tb/tb_wave_serializer.sv
// Bench for wave_serializer: directed pushes queue expected frames; a monitor
// reassembles each 64-bit serial frame and checks it against the queue.
module tb_wave_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [23:0] wave_in = '0;
    logic        wave_valid = 1'b0;
    logic        mute = 1'b0;
    logic        wave_ready, bclk, wsel, sdata;
    logic [2:0]  level;
    logic [7:0]  underrun;

    logic        rst_sat_n = 1'b1;
    logic        s_ready, s_bclk, s_wsel, s_sdata;
    logic [2:0]  s_level;
    logic [7:0]  s_underrun;

    int tb_cyc;
    int sat_cyc;
    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int          frame;
        logic [63:0] bits;
    } exp_t;
    exp_t sbq[$];

    wave_serializer #(.SAMPLE_WIDTH(24), .CLK_DIV(4), .FIFO_DEPTH_LOG2(2)) u_dut (
        .Clock(clk), .Reset(rst_n), .WaveIn(wave_in), .WaveValid(wave_valid),
        .WaveReady(wave_ready), .Mute(mute), .BitClk(bclk), .WordSel(wsel),
        .SerialData(sdata), .FifoLevel(level), .Underrun(underrun)
    );

    // Faster divider so the saturation run fits in a short simulation.
    wave_serializer #(.SAMPLE_WIDTH(24), .CLK_DIV(2), .FIFO_DEPTH_LOG2(2)) u_sat (
        .Clock(clk), .Reset(rst_sat_n), .WaveIn(24'h0), .WaveValid(1'b0),
        .WaveReady(s_ready), .Mute(1'b0), .BitClk(s_bclk), .WordSel(s_wsel),
        .SerialData(s_sdata), .FifoLevel(s_level), .Underrun(s_underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) tb_cyc <= 0;
        else        tb_cyc <= tb_cyc + 1;

    always @(posedge clk or negedge rst_sat_n)
        if (!rst_sat_n) sat_cyc <= 0;
        else            sat_cyc <= sat_cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic wait_cyc(input int n);
        while (tb_cyc < n) @(negedge clk);
    endtask

    task automatic push(input logic [23:0] d);
        wave_in    = d;
        wave_valid = 1'b1;
        @(negedge clk);
        wave_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: reassemble serial frames at each BitClk falling transition.
    initial begin
        int          fall, last, frame, pos;
        logic        prev;
        logic [63:0] bits, expf;
        fall = 0; last = 0; frame = 0; prev = 1'b0; bits = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                fall = 0; last = 0; frame = 0; prev = 1'b0; bits = '0;
            end else begin
                if (prev && !bclk) begin
                    chk("bclk_period", 64'(tb_cyc - last), 64'd8);
                    last = tb_cyc;
                    pos  = fall % 64;
                    chk("wordsel", 64'(wsel), 64'(pos >= 32));
                    bits = {bits[62:0], sdata};
                    if (pos == 63) begin
                        expf = '0;
                        if (sbq.size() > 0 && sbq[0].frame == frame) begin
                            expf = sbq[0].bits;
                            void'(sbq.pop_front());
                        end
                        chk($sformatf("frame%0d", frame), bits, expf);
                        frame++;
                    end
                    fall++;
                end
                prev = bclk;
            end
        end
    end

    task automatic main_seq();
        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_bclk", 64'(bclk), 64'd0);
        chk("rst_wsel", 64'(wsel), 64'd0);
        chk("rst_sdata", 64'(sdata), 64'd0);
        chk("rst_underrun", 64'(underrun), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_ready", 64'(wave_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle: two silent, underrunning frames
        wait_cyc(9);
        chk("idle_underrun_f0", 64'(underrun), 64'd1);
        wait_cyc(521);
        chk("idle_underrun_f1", 64'(underrun), 64'd2);
        chk("idle_level", 64'(level), 64'd0);
        wait_cyc(1030);

        // Single sample before first frame start
        do_reset();
        wait_cyc(1);
        push(24'h090807);
        sbq.push_back('{0, 64'h04840380_04840380});
        chk("one_level_pushed", 64'(level), 64'd1);
        wait_cyc(8);
        chk("one_level_popped", 64'(level), 64'd0);
        chk("one_underrun", 64'(underrun), 64'd0);

        // Overfill: four accepted, fifth dropped
        wait_cyc(600);
        chk("fill_ready_before", 64'(wave_ready), 64'd1);
        push(24'h123456);
        push(24'hFFFFFF);
        push(24'hA5A5A5);
        push(24'h000001);
        chk("fill_ready_full", 64'(wave_ready), 64'd0);
        push(24'hDEAD00);
        chk("fill_level", 64'(level), 64'd4);
        chk("fill_underrun", 64'(underrun), 64'd1);
        sbq.push_back('{2, 64'h091A2B00_091A2B00});
        sbq.push_back('{3, 64'h7FFFFF80_7FFFFF80});
        sbq.push_back('{4, 64'h52D2D280_52D2D280});
        sbq.push_back('{5, 64'h00000080_00000080});
        wait_cyc(1032);
        chk("fill_level_f2", 64'(level), 64'd3);
        chk("fill_ready_f2", 64'(wave_ready), 64'd1);

        // Muted frame still pops its sample
        wait_cyc(2700);
        push(24'h7FFFFF);
        wait_cyc(3000);
        mute = 1'b1;
        chk("mute_level_before", 64'(level), 64'd1);
        wait_cyc(3080);
        chk("mute_level_after", 64'(level), 64'd0);
        chk("mute_underrun", 64'(underrun), 64'd1);
        wait_cyc(3100);
        mute = 1'b0;
        wait_cyc(3200);
        push(24'h800001);
        sbq.push_back('{7, 64'h40000080_40000080});

        // Async reset mid left slot with three samples queued
        wait_cyc(4110);
        chk("pre_rst_underrun", 64'(underrun), 64'd2);
        wait_cyc(4120);
        push(24'h111111);
        push(24'h222222);
        push(24'h333333);
        wait_cyc(4200);
        chk("pre_rst_level", 64'(level), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_level", 64'(level), 64'd0);
        chk("mid_rst_ready", 64'(wave_ready), 64'd1);
        chk("mid_rst_underrun", 64'(underrun), 64'd0);
        chk("mid_rst_bclk", 64'(bclk), 64'd0);
        chk("mid_rst_sdata", 64'(sdata), 64'd0);
        chk("mid_rst_wsel", 64'(wsel), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(9);
        chk("post_rst_underrun", 64'(underrun), 64'd1);
        chk("post_rst_level", 64'(level), 64'd0);
        wait_cyc(520);
    endtask

    task automatic sat_seq();
        int frames[6] = '{0, 100, 253, 254, 255, 257};
        #2 rst_sat_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_sat_n = 1'b1;
        foreach (frames[i]) begin
            while (sat_cyc < 4 + 256 * frames[i]) @(negedge clk);
            chk($sformatf("sat_f%0d", frames[i]), 64'(s_underrun),
                64'((frames[i] + 1 > 255) ? 255 : frames[i] + 1));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            main_seq();
            sat_seq();
        join
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
